// File: rtl/mc_pkg.sv
// ============================================================================
// Module      : mc_pkg
// Description : Shared definitions for the multi-cycle MIPS-subset control
//               FSM: state encodings, ALU operation codes, opcode/funct
//               constants, instruction-class indices and datapath select
//               enums.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mc_pkg;

  // FSM state encodings. Code 7 is unused and is treated as S_HALT.
  localparam logic [2:0] S_RESET  = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_HALT   = 3'd6;

  // ALU operation codes; these must match the ALU's decoder bit for bit.
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SRL = 3'b100;
  localparam logic [2:0] ALU_SRA = 3'b101;

  // Primary opcodes (instr[31:26]).
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // R-type function codes (instr[5:0]).
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;

  // Bit positions inside the one-hot instruction class vector.
  localparam int IC_RTYPE = 0;
  localparam int IC_ORI   = 1;
  localparam int IC_LUI   = 2;
  localparam int IC_LW    = 3;
  localparam int IC_SW    = 4;
  localparam int IC_BEQ   = 5;
  localparam int IC_J     = 6;
  localparam int IC_W     = 7;

  // Register destination select.
  localparam logic [1:0] REG_DST_RT = 2'd0;
  localparam logic [1:0] REG_DST_RD = 2'd1;

  typedef enum logic [1:0] {
    PC_SRC_SEQ    = 2'd0,
    PC_SRC_BRANCH = 2'd1,
    PC_SRC_JUMP   = 2'd2
  } pc_src_e;

  typedef enum logic [1:0] {
    WD_SRC_ALU = 2'd0,
    WD_SRC_MDR = 2'd1,
    WD_SRC_LUI = 2'd2
  } wd_src_e;

  typedef enum logic [1:0] {
    ALU_B_RT    = 2'd0,
    ALU_B_IMM   = 2'd1,
    ALU_B_SHAMT = 2'd2
  } alu_src_b_e;

endpackage

`default_nettype wire

// File: rtl/mc_decode.sv
// ============================================================================
// Module      : mc_decode
// Description : Combinational instruction decoder. Classifies the IR into a
//               one-hot instruction class, supplies the ALU op for R-type
//               instructions and flags unsupported encodings.
// Ports       : instr      - IR contents
//               iclass     - one-hot class (see IC_* in mc_pkg)
//               r_alu_op   - ALU op for the R-type funct field
//               is_shift   - R-type instruction is srl/sra (B = shamt)
//               is_illegal - opcode/funct not supported
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mc_decode
  import mc_pkg::*;
(
  input  logic [31:0]     instr,
  output logic [IC_W-1:0] iclass,
  output logic [2:0]      r_alu_op,
  output logic            is_shift,
  output logic            is_illegal
);

  logic [5:0] op;
  logic [5:0] fn;
  // Register and immediate fields are irrelevant to control decoding.
  logic       unused_fields;

  assign op            = instr[31:26];
  assign fn            = instr[5:0];
  assign unused_fields = ^instr[25:6];

  always_comb begin
    iclass     = '0;
    r_alu_op   = ALU_ADD;
    is_shift   = 1'b0;
    is_illegal = 1'b0;
    case (op)
      OP_RTYPE: begin
        iclass[IC_RTYPE] = 1'b1;
        case (fn)
          FN_ADDU: r_alu_op = ALU_ADD;
          FN_SUBU: r_alu_op = ALU_SUB;
          FN_AND:  r_alu_op = ALU_AND;
          FN_OR:   r_alu_op = ALU_OR;
          FN_SRL: begin
            r_alu_op = ALU_SRL;
            is_shift = 1'b1;
          end
          FN_SRA: begin
            r_alu_op = ALU_SRA;
            is_shift = 1'b1;
          end
          default: begin
            // Unknown funct: not an R-type we execute.
            iclass     = '0;
            is_illegal = 1'b1;
          end
        endcase
      end
      OP_ORI:  iclass[IC_ORI] = 1'b1;
      OP_LUI:  iclass[IC_LUI] = 1'b1;
      OP_LW:   iclass[IC_LW]  = 1'b1;
      OP_SW:   iclass[IC_SW]  = 1'b1;
      OP_BEQ:  iclass[IC_BEQ] = 1'b1;
      OP_J:    iclass[IC_J]   = 1'b1;
      default: is_illegal     = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mc_ctrl.sv
// ============================================================================
// Module      : mc_ctrl
// Description : Multi-cycle control FSM for the MIPS-subset CPU. Sequences
//               fetch/decode/execute/memory/writeback, drives ALU op, all
//               datapath strobes and selects, and handshakes with a
//               variable-latency memory through mem_req/mem_ready.
// Ports       : clk, rst_n            - clock, async active-low reset
//               instr, zero, mem_ready - IR, ALU zero flag, memory done
//               mem_req, mem_we        - memory request / write qualifier
//               ir_we, pc_we, pc_src   - IR and PC load controls
//               reg_we, reg_dst, wd_src- register file write controls
//               alu_src_b, ext_op, alu_op - ALU operand/op controls
//               state, illegal         - debug state, sticky illegal flag
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mc_ctrl
  import mc_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_src,
  output logic        reg_we,
  output logic [1:0]  reg_dst,
  output logic [1:0]  wd_src,
  output logic [1:0]  alu_src_b,
  output logic        ext_op,
  output logic [2:0]  alu_op,
  output logic [2:0]  state,
  output logic        illegal
);

  logic [2:0]      state_q;
  logic [2:0]      state_d;
  logic [IC_W-1:0] iclass;
  logic [2:0]      r_alu_op;
  logic            is_shift;
  logic            is_illegal;

  mc_decode u_decode (
    .instr      (instr),
    .iclass     (iclass),
    .r_alu_op   (r_alu_op),
    .is_shift   (is_shift),
    .is_illegal (is_illegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RESET;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

  // Next-state and output logic. Outputs depend only on state_q, instr,
  // zero and mem_ready, so they are stable within a state once IR settles.
  always_comb begin
    state_d   = state_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_src    = PC_SRC_SEQ;
    reg_we    = 1'b0;
    reg_dst   = REG_DST_RT;
    wd_src    = WD_SRC_ALU;
    alu_src_b = ALU_B_RT;
    ext_op    = 1'b0;
    alu_op    = ALU_ADD;
    illegal   = 1'b0;
    case (state_q)
      S_RESET: state_d = S_FETCH;

      S_FETCH: begin
        mem_req = 1'b1;
        // IR and PC+4 are captured on the same edge the memory completes.
        if (mem_ready) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          state_d = S_DECODE;
        end
      end

      S_DECODE: begin
        if (is_illegal) begin
          state_d = S_HALT;
        end else if (iclass[IC_J]) begin
          pc_we   = 1'b1;
          pc_src  = PC_SRC_JUMP;
          state_d = S_FETCH;
        end else begin
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        state_d = S_WB;
        if (iclass[IC_RTYPE]) begin
          alu_op    = r_alu_op;
          alu_src_b = is_shift ? ALU_B_SHAMT : ALU_B_RT;
        end else if (iclass[IC_ORI]) begin
          alu_op    = ALU_OR;
          alu_src_b = ALU_B_IMM;
        end else if (iclass[IC_LW] || iclass[IC_SW]) begin
          alu_src_b = ALU_B_IMM;
          ext_op    = 1'b1;
          state_d   = S_MEM;
        end else if (iclass[IC_BEQ]) begin
          alu_op  = ALU_SUB;
          state_d = S_FETCH;
          if (zero) begin
            pc_we  = 1'b1;
            pc_src = PC_SRC_BRANCH;
          end
        end
        // lui needs no ALU work: its writeback data comes straight from imm16.
      end

      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = iclass[IC_SW];
        if (mem_ready) begin
          state_d = iclass[IC_LW] ? S_WB : S_FETCH;
        end
      end

      S_WB: begin
        reg_we  = 1'b1;
        reg_dst = iclass[IC_RTYPE] ? REG_DST_RD : REG_DST_RT;
        if (iclass[IC_LW]) begin
          wd_src = WD_SRC_MDR;
        end else if (iclass[IC_LUI]) begin
          wd_src = WD_SRC_LUI;
        end
        state_d = S_FETCH;
      end

      // S_HALT and the unused code 7: absorbing, only reset leaves.
      default: begin
        illegal = 1'b1;
        state_d = S_HALT;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_mc_ctrl.sv
// ============================================================================
// Module      : tb_mc_ctrl
// Description : Self-checking bench for mc_ctrl. A behavioural model expands
//               each instruction into its expected per-cycle output trace,
//               which is replayed against the DUT cycle by cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mc_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr = 32'h0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        mem_req, mem_we, ir_we, pc_we, reg_we, ext_op, illegal;
  logic [1:0]  pc_src, reg_dst, wd_src, alu_src_b;
  logic [2:0]  alu_op, state;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mc_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .instr     (instr),
    .zero      (zero),
    .mem_ready (mem_ready),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .ir_we     (ir_we),
    .pc_we     (pc_we),
    .pc_src    (pc_src),
    .reg_we    (reg_we),
    .reg_dst   (reg_dst),
    .wd_src    (wd_src),
    .alu_src_b (alu_src_b),
    .ext_op    (ext_op),
    .alu_op    (alu_op),
    .state     (state),
    .illegal   (illegal)
  );

  // One expected cycle: inputs to apply and the full output vector expected.
  typedef struct {
    logic [31:0] ins;
    logic        rdy;
    logic        z;
    logic [20:0] exp;
  } cyc_t;

  cyc_t        q[$];
  logic [31:0] prev_instr = 32'h0;

  // Instruction kinds used by the model.
  localparam int K_ADDU = 0, K_SUBU = 1, K_AND = 2, K_OR = 3, K_SRL = 4,
                 K_SRA = 5, K_ORI = 6, K_LUI = 7, K_LW = 8, K_SW = 9,
                 K_BEQ = 10, K_J = 11, K_ILL = -1;

  function automatic logic [20:0] pk(
    input logic [2:0] st, input logic mreq, input logic mwe,
    input logic irwe, input logic pcwe, input logic [1:0] pcs,
    input logic rwe, input logic [1:0] rdst, input logic [1:0] wds,
    input logic [1:0] bsrc, input logic ext, input logic [2:0] aop,
    input logic ill);
    return {st, mreq, mwe, irwe, pcwe, pcs, rwe, rdst, wds, bsrc, ext, aop, ill};
  endfunction

  function automatic logic [20:0] observed();
    return {state, mem_req, mem_we, ir_we, pc_we, pc_src, reg_we, reg_dst,
            wd_src, alu_src_b, ext_op, alu_op, illegal};
  endfunction

  function automatic int classify(input logic [31:0] ins);
    logic [5:0] op;
    logic [5:0] fn;
    op = ins[31:26];
    fn = ins[5:0];
    if (op == 6'h00) begin
      if (fn == 6'h21) return K_ADDU;
      if (fn == 6'h23) return K_SUBU;
      if (fn == 6'h24) return K_AND;
      if (fn == 6'h25) return K_OR;
      if (fn == 6'h02) return K_SRL;
      if (fn == 6'h03) return K_SRA;
      return K_ILL;
    end
    if (op == 6'h0D) return K_ORI;
    if (op == 6'h0F) return K_LUI;
    if (op == 6'h23) return K_LW;
    if (op == 6'h2B) return K_SW;
    if (op == 6'h04) return K_BEQ;
    if (op == 6'h02) return K_J;
    return K_ILL;
  endfunction

  function automatic logic [31:0] mk_instr(input int k);
    logic [5:0] fn_tab [6];
    logic [5:0] op_tab [6];
    fn_tab = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h02, 6'h03};
    op_tab = '{6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h02};
    if (k <= K_SRA) return {6'h00, 20'($urandom), fn_tab[k]};
    return {op_tab[k - K_ORI], 26'($urandom)};
  endfunction

  function automatic void push(input logic [31:0] ins, input logic rdy,
                               input logic z, input logic [20:0] exp);
    cyc_t c;
    c.ins = ins; c.rdy = rdy; c.z = z; c.exp = exp;
    q.push_back(c);
  endfunction

  // Expand one instruction into its expected cycle trace.
  function automatic void add_instr(input logic [31:0] ins, input int fwait,
                                    input int mwait, input logic z,
                                    input int halt_cycles);
    int         k;
    logic [2:0] aop;
    logic [1:0] bsrc;
    logic       taken;
    k = classify(ins);
    for (int i = 0; i < fwait; i++)
      push(prev_instr, 1'b0, 1'($urandom), pk(3'd1, 1,0,0,0, 2'd0, 0, 2'd0, 2'd0, 2'd0, 0, 3'd0, 0));
    push(prev_instr, 1'b1, 1'($urandom), pk(3'd1, 1,0,1,1, 2'd0, 0, 2'd0, 2'd0, 2'd0, 0, 3'd0, 0));
    prev_instr = ins;
    if (k == K_J) begin
      push(ins, 1'($urandom), 1'($urandom), pk(3'd2, 0,0,0,1, 2'd2, 0, 2'd0, 2'd0, 2'd0, 0, 3'd0, 0));
      return;
    end
    push(ins, 1'($urandom), 1'($urandom), pk(3'd2, 0,0,0,0, 2'd0, 0, 2'd0, 2'd0, 2'd0, 0, 3'd0, 0));
    if (k == K_ILL) begin
      for (int i = 0; i < halt_cycles; i++)
        push(ins, 1'($urandom), 1'($urandom), pk(3'd6, 0,0,0,0, 2'd0, 0, 2'd0, 2'd0, 2'd0, 0, 3'd0, 1));
      return;
    end
    // ALU op table: R-type kinds are listed in ALU-code order.
    if (k <= K_SRA)      aop = 3'(k);
    else if (k == K_ORI) aop = 3'b011;
    else if (k == K_BEQ) aop = 3'b001;
    else                 aop = 3'b000;
    if (k == K_SRL || k == K_SRA)                bsrc = 2'd2;
    else if (k == K_ORI || k == K_LW || k == K_SW) bsrc = 2'd1;
    else                                         bsrc = 2'd0;
    taken = (k == K_BEQ) && z;
    push(ins, 1'($urandom), z, pk(3'd3, 0,0,0,taken, taken ? 2'd1 : 2'd0, 0, 2'd0, 2'd0,
                                  bsrc, (k == K_LW || k == K_SW), aop, 0));
    if (k == K_BEQ) return;
    if (k == K_LW || k == K_SW) begin
      for (int i = 0; i <= mwait; i++)
        push(ins, (i == mwait), 1'($urandom),
             pk(3'd4, 1, (k == K_SW), 0,0, 2'd0, 0, 2'd0, 2'd0, 2'd0, 0, 3'd0, 0));
      if (k == K_SW) return;
    end
    push(ins, 1'($urandom), 1'($urandom),
         pk(3'd5, 0,0,0,0, 2'd0, 1, (k <= K_SRA) ? 2'd1 : 2'd0,
            (k == K_LW) ? 2'd1 : ((k == K_LUI) ? 2'd2 : 2'd0), 2'd0, 0, 3'd0, 0));
  endfunction

  // Apply one cycle of stimulus and sample outputs mid-cycle.
  task automatic step(input cyc_t c, output logic [20:0] o);
    @(negedge clk);
    instr     = c.ins;
    mem_ready = c.rdy;
    zero      = c.z;
    #1;
    o = observed();
  endtask

  task automatic test_reset();
    logic [20:0] o;
    mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      o = observed();
      n_tests++;
      if (o !== 21'd0) begin
        n_fail++;
        $display("FAIL reset_hold cyc %0d: got %h expected %h", i, o, 21'd0);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    o = observed();
    n_tests++;
    if (o !== 21'd0) begin
      n_fail++;
      $display("FAIL reset_release: got %h expected %h", o, 21'd0);
    end
  endtask

  task automatic test_addu();
    logic [20:0] o;
    int n;
    add_instr(32'h00221821, 0, 0, 1'b0, 0);
    n = 0;
    while (q.size() > 0) begin
      cyc_t c = q.pop_front();
      step(c, o);
      n_tests++;
      if (o !== c.exp) begin
        n_fail++;
        $display("FAIL addu cyc %0d: got %h expected %h", n, o, c.exp);
      end
      n++;
    end
  endtask

  task automatic test_lw_wait();
    logic [20:0] o;
    int n;
    add_instr(32'h8C220004, 1, 2, 1'b0, 0);
    n = 0;
    while (q.size() > 0) begin
      cyc_t c = q.pop_front();
      step(c, o);
      n_tests++;
      if (o !== c.exp) begin
        n_fail++;
        $display("FAIL lw_wait cyc %0d: got %h expected %h", n, o, c.exp);
      end
      n++;
    end
  endtask

  task automatic test_beq();
    logic [20:0] o;
    int n;
    add_instr(32'h10220003, 0, 0, 1'b1, 0);
    add_instr(32'h10220003, 0, 0, 1'b0, 0);
    n = 0;
    while (q.size() > 0) begin
      cyc_t c = q.pop_front();
      step(c, o);
      n_tests++;
      if (o !== c.exp) begin
        n_fail++;
        $display("FAIL beq cyc %0d: got %h expected %h", n, o, c.exp);
      end
      n++;
    end
  endtask

  task automatic test_shifts();
    logic [20:0] o;
    int n;
    add_instr(32'h00021082, 0, 0, 1'b0, 0);
    add_instr(32'h00021083, 2, 0, 1'b1, 0);
    n = 0;
    while (q.size() > 0) begin
      cyc_t c = q.pop_front();
      step(c, o);
      n_tests++;
      if (o !== c.exp) begin
        n_fail++;
        $display("FAIL shifts cyc %0d: got %h expected %h", n, o, c.exp);
      end
      n++;
    end
  endtask

  task automatic test_random();
    logic [20:0] o;
    int n;
    for (int i = 0; i < 40; i++)
      add_instr(mk_instr($urandom_range(0, 11)), $urandom_range(0, 3),
                $urandom_range(0, 3), 1'($urandom), 0);
    n = 0;
    while (q.size() > 0) begin
      cyc_t c = q.pop_front();
      step(c, o);
      n_tests++;
      if (o !== c.exp) begin
        n_fail++;
        $display("FAIL random cyc %0d: got %h expected %h", n, o, c.exp);
      end
      n++;
    end
  endtask

  task automatic test_reset_mid_mem();
    logic [20:0] o;
    cyc_t        c;
    // sw with a long memory wait; cut it off during the second S_MEM cycle.
    add_instr(32'hAC220000, 0, 6, 1'b0, 0);
    for (int i = 0; i < 5; i++) begin
      c = q.pop_front();
      step(c, o);
      n_tests++;
      if (o !== c.exp) begin
        n_fail++;
        $display("FAIL sw_pre_reset cyc %0d: got %h expected %h", i, o, c.exp);
      end
    end
    q.delete();
    #2;
    rst_n = 1'b0;
    #1;
    o = observed();
    n_tests++;
    if (o !== 21'd0) begin
      n_fail++;
      $display("FAIL reset_mid_mem: got %h expected %h", o, 21'd0);
    end
    mem_ready = 1'b1;
    @(negedge clk); #1;
    o = observed();
    n_tests++;
    if (o !== 21'd0) begin
      n_fail++;
      $display("FAIL reset_mid_mem_hold: got %h expected %h", o, 21'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    o = observed();
    n_tests++;
    if (o !== 21'd0) begin
      n_fail++;
      $display("FAIL reset_mid_mem_release: got %h expected %h", o, 21'd0);
    end
    add_instr(32'h00221821, 0, 0, 1'b0, 0);
    while (q.size() > 0) begin
      c = q.pop_front();
      step(c, o);
      n_tests++;
      if (o !== c.exp) begin
        n_fail++;
        $display("FAIL after_reset: got %h expected %h", o, c.exp);
      end
    end
  endtask

  task automatic test_illegal();
    logic [20:0] o;
    cyc_t        c;
    int n;
    add_instr(32'hFC000000, 1, 0, 1'b0, 20);
    n = 0;
    while (q.size() > 0) begin
      c = q.pop_front();
      step(c, o);
      n_tests++;
      if (o !== c.exp) begin
        n_fail++;
        $display("FAIL illegal cyc %0d: got %h expected %h", n, o, c.exp);
      end
      n++;
    end
    // Only reset clears the sticky flag.
    #2;
    rst_n = 1'b0;
    #1;
    o = observed();
    n_tests++;
    if (o !== 21'd0) begin
      n_fail++;
      $display("FAIL illegal_clear: got %h expected %h", o, 21'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    add_instr(32'h3C011234, 0, 0, 1'b0, 0);
    while (q.size() > 0) begin
      c = q.pop_front();
      step(c, o);
      n_tests++;
      if (o !== c.exp) begin
        n_fail++;
        $display("FAIL post_illegal: got %h expected %h", o, c.exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_addu();
    test_lw_wait();
    test_beq();
    test_shifts();
    test_random();
    test_reset_mid_mem();
    test_illegal();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
